// File: rtl/psg_write_arbiter.sv
// rtl/psg_write_arbiter.sv - round-robin two-requester command sequencer for the PSG write bus
module psg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ready,
    output logic                   nonempty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign ready    = (count < FULL_COUNT);
    assign nonempty = (count != '0);
    assign push_en  = push && ready;
    assign pop_en   = pop && nonempty;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module psg_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic                   a_two,
    input  logic [7:0]             a_d0,
    input  logic [7:0]             a_d1,
    output logic [$clog2(DEPTH):0] a_count,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic                   b_two,
    input  logic [7:0]             b_d0,
    input  logic [7:0]             b_d1,
    output logic [$clog2(DEPTH):0] b_count,
    output logic                   psg_nWE,
    output logic                   psg_nCE,
    output logic [7:0]             psg_D,
    input  logic                   psg_READY,
    output logic                   busy
);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {IDLE, WR0, WAIT0, WR1, WAIT1, GAP} state_t;

    state_t        state;
    logic          last_grant_b;
    logic          cmd_two;
    logic [7:0]    cmd_d1;
    logic          wait_first;
    logic [GW-1:0] gap_cnt;

    logic [16:0]   a_head;
    logic [16:0]   b_head;
    logic [16:0]   win_head;
    logic          a_ne;
    logic          b_ne;
    logic          start;
    logic          pop_a;
    logic          pop_b;

    psg_cmd_fifo #(.DEPTH(DEPTH), .W(17)) u_fifo_a (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (a_valid),
        .din      ({a_two, a_d0, a_d1}),
        .pop      (pop_a),
        .dout     (a_head),
        .count    (a_count),
        .ready    (a_ready),
        .nonempty (a_ne)
    );

    psg_cmd_fifo #(.DEPTH(DEPTH), .W(17)) u_fifo_b (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (b_valid),
        .din      ({b_two, b_d0, b_d1}),
        .pop      (pop_b),
        .dout     (b_head),
        .count    (b_count),
        .ready    (b_ready),
        .nonempty (b_ne)
    );

    // Pops only happen from IDLE, so a command in flight can never lose its grant.
    assign start    = (state == IDLE) && psg_READY && (a_ne || b_ne);
    assign pop_a    = start && a_ne && (!b_ne || last_grant_b);
    assign pop_b    = start && !pop_a;
    assign win_head = pop_a ? a_head : b_head;
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            cmd_two      <= 1'b0;
            cmd_d1       <= 8'h00;
            wait_first   <= 1'b0;
            gap_cnt      <= '0;
            psg_nWE      <= 1'b1;
            psg_nCE      <= 1'b1;
            psg_D        <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_two      <= win_head[16];
                        cmd_d1       <= win_head[7:0];
                        last_grant_b <= pop_b;
                        psg_nWE      <= 1'b0;
                        psg_nCE      <= 1'b0;
                        psg_D        <= win_head[15:8];
                        state        <= WR0;
                    end
                end
                WR0, WR1: begin
                    psg_nWE    <= 1'b1;
                    psg_nCE    <= 1'b1;
                    wait_first <= 1'b1;
                    state      <= (state == WR0) ? WAIT0 : WAIT1;
                end
                WAIT0, WAIT1: begin
                    wait_first <= 1'b0;
                    // The PSG drops READY a cycle after the strobe, so the first wait cycle never exits.
                    if (psg_READY && !wait_first) begin
                        if (state == WAIT0 && cmd_two) begin
                            psg_nWE <= 1'b0;
                            psg_nCE <= 1'b0;
                            psg_D   <= cmd_d1;
                            state   <= WR1;
                        end else if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psg_write_arbiter.sv
// tb/tb_psg_write_arbiter.sv - directed bench for psg_write_arbiter with a small PSG model
module tb_psg_write_arbiter;
    logic       CLK = 1'b0;
    logic       nRST = 1'b1;
    logic       a_valid = 1'b0;
    logic       a_two = 1'b0;
    logic [7:0] a_d0 = 8'h00;
    logic [7:0] a_d1 = 8'h00;
    logic       a_ready;
    logic [2:0] a_count;
    logic       b_valid = 1'b0;
    logic       b_two = 1'b0;
    logic [7:0] b_d0 = 8'h00;
    logic [7:0] b_d1 = 8'h00;
    logic       b_ready;
    logic [2:0] b_count;
    logic       psg_nWE;
    logic       psg_nCE;
    logic [7:0] psg_D;
    logic       psg_READY = 1'b1;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] log_d[$];
    int         log_t[$];
    logic [9:0] tone [4] = '{default: '0};
    logic [3:0] vol  [4] = '{default: '0};
    logic [1:0] lch = 2'd0;
    logic       lvol = 1'b0;
    int         pending = 0;
    int         stretch_idx = -1;
    logic       hold_low = 1'b0;

    psg_write_arbiter #(.DEPTH(4), .GAP_CYCLES(1)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_two     (a_two),
        .a_d0      (a_d0),
        .a_d1      (a_d1),
        .a_count   (a_count),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_two     (b_two),
        .b_d0      (b_d0),
        .b_d1      (b_d1),
        .b_count   (b_count),
        .psg_nWE   (psg_nWE),
        .psg_nCE   (psg_nCE),
        .psg_D     (psg_D),
        .psg_READY (psg_READY),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // PSG model: logs strobes, decodes latch/data bytes, drops READY after each strobe
    always @(negedge CLK) begin
        if (!psg_nWE && !psg_nCE) begin
            pending = (log_d.size() == stretch_idx) ? 5 : 1;
            log_d.push_back(psg_D);
            log_t.push_back(cyc);
            if (psg_D[7]) begin
                lch  = psg_D[6:5];
                lvol = psg_D[4];
                if (psg_D[4]) vol[psg_D[6:5]] = psg_D[3:0];
                else tone[psg_D[6:5]][3:0] = psg_D[3:0];
            end else if (!lvol) begin
                tone[lch][9:4] = psg_D[5:0];
            end
        end else if (pending > 0) begin
            psg_READY = 1'b0;
            pending--;
        end else begin
            psg_READY = !hold_low;
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic push_a(input logic two, input logic [7:0] d0, input logic [7:0] d1);
        @(posedge CLK);
        #1;
        a_valid = 1'b1; a_two = two; a_d0 = d0; a_d1 = d1;
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!(busy == 1'b0 && a_count == 3'd0 && b_count == 3'd0) && n < 300);
        total++;
        if (n >= 300) begin bad++; $display("FAIL %s_idle_timeout busy=%0b a_count=%0d b_count=%0d", name, busy, a_count, b_count); end
    endtask

    task automatic test_reset();
        #2;
        nRST = 1'b0;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_a_ready got=%0b want=1", a_ready); end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL rst_b_ready got=%0b want=1", b_ready); end
        total++; if (a_count !== 3'd0) begin bad++; $display("FAIL rst_a_count got=%0d want=0", a_count); end
        total++; if (b_count !== 3'd0) begin bad++; $display("FAIL rst_b_count got=%0d want=0", b_count); end
        total++; if (psg_nWE !== 1'b1) begin bad++; $display("FAIL rst_nwe got=%0b want=1", psg_nWE); end
        total++; if (psg_nCE !== 1'b1) begin bad++; $display("FAIL rst_nce got=%0b want=1", psg_nCE); end
        total++; if (psg_D !== 8'h00) begin bad++; $display("FAIL rst_d got=%h want=00", psg_D); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_one_byte();
        int base;
        int n;
        base = log_d.size();
        @(posedge CLK);
        #1;
        a_valid = 1'b1; a_two = 1'b0; a_d0 = 8'h9F; a_d1 = 8'h00;
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
        total++; if (a_count !== 3'd1) begin bad++; $display("FAIL one_count got=%0d want=1", a_count); end
        total++; if (psg_nWE !== 1'b1) begin bad++; $display("FAIL one_early_nwe got=%0b want=1", psg_nWE); end
        @(posedge CLK);
        #1;
        total++; if (psg_nWE !== 1'b0) begin bad++; $display("FAIL one_nwe got=%0b want=0", psg_nWE); end
        total++; if (psg_nCE !== 1'b0) begin bad++; $display("FAIL one_nce got=%0b want=0", psg_nCE); end
        total++; if (psg_D !== 8'h9F) begin bad++; $display("FAIL one_d got=%h want=9f", psg_D); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL one_busy got=%0b want=1", busy); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (!busy) break;
            n++;
        end
        total++; if (n != 4) begin bad++; $display("FAIL one_busy_len got=%0d want=4", n); end
        total++; if (log_d.size() - base != 1) begin bad++; $display("FAIL one_strobes got=%0d want=1", log_d.size() - base); end
        total++; if (vol[0] !== 4'hF) begin bad++; $display("FAIL one_vol0 got=%h want=f", vol[0]); end
    endtask

    task automatic test_two_byte();
        int base;
        base = log_d.size();
        push_a(1'b1, 8'h8C, 8'h1A);
        wait_idle("two");
        total++; if (log_d.size() - base != 2) begin bad++; $display("FAIL two_strobes got=%0d want=2", log_d.size() - base); end
        if (log_d.size() - base == 2) begin
            total++; if (log_d[base] !== 8'h8C) begin bad++; $display("FAIL two_byte0 got=%h want=8c", log_d[base]); end
            total++; if (log_d[base+1] !== 8'h1A) begin bad++; $display("FAIL two_byte1 got=%h want=1a", log_d[base+1]); end
            total++; if (log_t[base+1] - log_t[base] != 3) begin bad++; $display("FAIL two_spacing got=%0d want=3", log_t[base+1] - log_t[base]); end
        end
        total++; if (tone[0] !== 10'h1AC) begin bad++; $display("FAIL two_tone0 got=%h want=1ac", tone[0]); end
    endtask

    task automatic test_simultaneous();
        int base;
        logic [7:0] exp_d [8];
        exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
        do_reset();
        base = log_d.size();
        @(posedge CLK);
        #1;
        a_valid = 1'b1; a_two = 1'b1; a_d0 = 8'hA0; a_d1 = 8'hA1;
        b_valid = 1'b1; b_two = 1'b1; b_d0 = 8'hB0; b_d1 = 8'hB1;
        @(posedge CLK);
        #1;
        a_d0 = 8'hA2; a_d1 = 8'hA3;
        b_d0 = 8'hB2; b_d1 = 8'hB3;
        @(posedge CLK);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_idle("sim");
        total++; if (log_d.size() - base != 8) begin bad++; $display("FAIL sim_strobes got=%0d want=8", log_d.size() - base); end
        if (log_d.size() - base == 8) begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (log_d[base+i] !== exp_d[i]) begin bad++; $display("FAIL sim_order[%0d] got=%h want=%h", i, log_d[base+i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_back_pressure();
        int base;
        hold_low = 1'b1;
        @(negedge CLK);
        base = log_d.size();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            b_valid = 1'b1; b_two = 1'b0; b_d0 = 8'h91 + i[7:0]; b_d1 = 8'h00;
            @(posedge CLK);
            #1;
            if (i == 3) begin
                total++; if (b_count !== 3'd4) begin bad++; $display("FAIL bp_count4 got=%0d want=4", b_count); end
                total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%0b want=0", b_ready); end
            end
        end
        b_valid = 1'b0;
        total++; if (b_count !== 3'd4) begin bad++; $display("FAIL bp_count_after5 got=%0d want=4", b_count); end
        total++; if (log_d.size() != base) begin bad++; $display("FAIL bp_no_strobe got=%0d want=0", log_d.size() - base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%0b want=0", busy); end
        hold_low = 1'b0;
        wait_idle("bp");
        total++; if (log_d.size() - base != 4) begin bad++; $display("FAIL bp_drained got=%0d want=4", log_d.size() - base); end
        if (log_d.size() - base == 4) begin
            total++; if (log_d[base+3] !== 8'h94) begin bad++; $display("FAIL bp_last got=%h want=94", log_d[base+3]); end
        end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0b want=1", b_ready); end
    endtask

    task automatic test_reset_mid();
        int base;
        base = log_d.size();
        @(posedge CLK);
        #1;
        a_valid = 1'b1; a_two = 1'b1; a_d0 = 8'h8C; a_d1 = 8'h1A;
        @(posedge CLK);
        #1;
        a_two = 1'b0; a_d0 = 8'h9F; a_d1 = 8'h00;
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
        @(posedge CLK);
        #1;
        total++; if (busy !== 1'b1 || psg_nWE !== 1'b1) begin bad++; $display("FAIL rm_in_wait got busy=%0b nwe=%0b want busy=1 nwe=1", busy, psg_nWE); end
        nRST = 1'b0;
        #1;
        total++; if (psg_nWE !== 1'b1 || psg_nCE !== 1'b1) begin bad++; $display("FAIL rm_strobes got nwe=%0b nce=%0b want 1/1", psg_nWE, psg_nCE); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b want=0", busy); end
        total++; if (a_count !== 3'd0) begin bad++; $display("FAIL rm_a_count got=%0d want=0", a_count); end
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        total++; if (log_d.size() - base != 1) begin bad++; $display("FAIL rm_strobes_total got=%0d want=1", log_d.size() - base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy_after got=%0b want=0", busy); end
    endtask

    task automatic test_ready_stretch();
        int base;
        base = log_d.size();
        stretch_idx = base;
        push_a(1'b1, 8'h85, 8'h3F);
        wait_idle("stretch");
        stretch_idx = -1;
        total++; if (log_d.size() - base != 2) begin bad++; $display("FAIL st_strobes got=%0d want=2", log_d.size() - base); end
        if (log_d.size() - base == 2) begin
            total++; if (log_t[base+1] - log_t[base] != 7) begin bad++; $display("FAIL st_spacing got=%0d want=7", log_t[base+1] - log_t[base]); end
            total++; if (log_d[base+1] !== 8'h3F) begin bad++; $display("FAIL st_byte1 got=%h want=3f", log_d[base+1]); end
        end
        total++; if (tone[0] !== 10'h3F5) begin bad++; $display("FAIL st_tone0 got=%h want=3f5", tone[0]); end
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_two_byte();
        test_simultaneous();
        test_back_pressure();
        test_reset_mid();
        test_ready_stretch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
